// File: rtl/alu32_seq.sv
// Command sequencer in front of a registered 32-bit ALU: owns an 8x32 register file,
// issues register-to-register ops, writes results back and returns them on a response channel.
module alu32_seq #(
  parameter int unsigned REG_AW = 3,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [REG_AW-1:0] cmd_rs1,
  input  logic [REG_AW-1:0] cmd_rs2,
  input  logic [REG_AW-1:0] cmd_rd,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [REG_AW-1:0] rsp_rd,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy
);

  localparam int unsigned NumRegs = 2 ** REG_AW;

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StResp} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] regs_q [NumRegs];
  logic [DATA_W-1:0] regs_d [NumRegs];
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [2:0]        alu_op_q, alu_op_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [REG_AW-1:0] rsp_rd_q, rsp_rd_d;

  always_comb begin
    state_d     = state_q;
    regs_d      = regs_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rd_d        = rd_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_rd_d    = rsp_rd_q;

    if (wr_en) begin
      regs_d[wr_addr] = wr_data;
    end

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          // Operands come from regs_q, so a same-cycle host write is not bypassed.
          alu_a_d  = regs_q[cmd_rs1];
          alu_b_d  = regs_q[cmd_rs2];
          alu_op_d = cmd_op;
          rd_d     = cmd_rd;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        // NOP from the next cycle on keeps the ALU holding its freshly registered result.
        alu_op_d = 3'b000;
        state_d  = StCapture;
      end
      StCapture: begin
        // Assigned after the host write so the writeback wins on an address collision.
        regs_d[rd_q] = alu_result;
        rsp_data_d   = alu_result;
        rsp_rd_d     = rd_q;
        rsp_valid_d  = 1'b1;
        state_d      = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= 3'b000;
      rd_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_rd_q    <= '0;
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rd_q        <= rd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_rd_q    <= rsp_rd_d;
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_rd    = rsp_rd_q;

endmodule

// File: tb/tb_alu32_seq.sv
// Directed bench for alu32_seq with a behavioural registered ALU attached to its ALU ports.
module tb_alu32_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_rs1, cmd_rs2, cmd_rd;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_rd;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_result;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu32_seq #(.REG_AW(3), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_rs1    (cmd_rs1),
    .cmd_rs2    (cmd_rs2),
    .cmd_rd     (cmd_rd),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_rd     (rsp_rd),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .busy       (busy)
  );

  // Registered ALU model; its active-low reset is the inverse of the sequencer reset.
  always @(posedge clk) begin
    if (reset) begin
      alu_result <= 32'h0;
    end else begin
      case (alu_op)
        3'b001:  alu_result <= ~alu_a;
        3'b010:  alu_result <= alu_a & alu_b;
        3'b011:  alu_result <= alu_a | alu_b;
        3'b100:  alu_result <= alu_a ^ alu_b;
        3'b101:  alu_result <= ~(alu_a ^ alu_b);
        3'b110:  alu_result <= alu_a + alu_b;
        3'b111:  alu_result <= alu_a - alu_b;
        default: alu_result <= alu_result;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic host_wr(input logic [2:0] addr, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  // Accepts one command and waits (bounded) for rsp_valid, checking the 3-cycle latency.
  task automatic send_cmd(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                          input logic [2:0] rs2);
    int lat;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_rs1   = rs1;
    cmd_rs2   = rs2;
    chk("cmd_ready_at_accept", {31'b0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      tick();
      lat++;
    end
    chk("rsp_latency", lat, 32'd3);
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("idle_after_rsp", {30'b0, cmd_ready, busy}, 32'b10);
  endtask

  task automatic read_reg(input logic [2:0] r, input logic [31:0] exp, input string name);
    send_cmd(3'b011, r, r, r);
    chk(name, rsp_data, exp);
    finish_rsp();
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{3'b111, 3'd3, 3'd1, 3'd2, 32'hFFFF_FFFE};  // SUB 5-7
    vecs[1]  = '{3'b011, 3'd3, 3'd3, 3'd3, 32'hFFFF_FFFE};  // readback R3
    vecs[2]  = '{3'b110, 3'd4, 3'd4, 3'd5, 32'h0000_0000};  // ADD wrap, rd==rs1
    vecs[3]  = '{3'b011, 3'd4, 3'd4, 3'd4, 32'h0000_0000};  // readback R4
    vecs[4]  = '{3'b001, 3'd7, 3'd6, 3'd0, 32'hF0F0_F0F0};  // NOT
    vecs[5]  = '{3'b101, 3'd0, 3'd6, 3'd7, 32'h0000_0000};  // XNOR
    vecs[6]  = '{3'b000, 3'd2, 3'd0, 3'd0, 32'h0000_0000};  // NOP holds last result
    vecs[7]  = '{3'b011, 3'd2, 3'd2, 3'd2, 32'h0000_0000};  // readback R2
    vecs[8]  = '{3'b010, 3'd5, 3'd1, 3'd6, 32'h0000_0005};  // AND
    vecs[9]  = '{3'b100, 3'd1, 3'd1, 3'd5, 32'h0000_0000};  // XOR
    vecs[10] = '{3'b110, 3'd6, 3'd6, 3'd6, 32'h1E1E_1E1E};  // ADD
    vecs[11] = '{3'b111, 3'd0, 3'd0, 3'd6, 32'hE1E1_E1E2};  // SUB 0 - x

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'b0;
    cmd_rs1   = 3'd0;
    cmd_rs2   = 3'd0;
    cmd_rd    = 3'd0;
    wr_en     = 1'b0;
    wr_addr   = 3'd0;
    wr_data   = 32'h0;
    rsp_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    chk("reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_rsp_data", rsp_data, 32'h0);
    chk("reset_rsp_rd", {29'b0, rsp_rd}, 32'd0);
    chk("reset_alu_a", alu_a, 32'h0);
    chk("reset_alu_b", alu_b, 32'h0);
    chk("reset_alu_op", {29'b0, alu_op}, 32'd0);

    host_wr(3'd1, 32'd5);
    host_wr(3'd2, 32'd7);
    host_wr(3'd4, 32'hFFFF_FFFF);
    host_wr(3'd5, 32'd1);
    host_wr(3'd6, 32'h0F0F_0F0F);

    for (int i = 0; i < 12; i++) begin
      send_cmd(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2);
      chk($sformatf("vec%0d_data", i), rsp_data, vecs[i].exp);
      chk($sformatf("vec%0d_rd", i), {29'b0, rsp_rd}, {29'b0, vecs[i].rd});
      finish_rsp();
    end

    // Response back-pressure: everything holds while rsp_ready is low.
    send_cmd(3'b011, 3'd2, 3'd6, 3'd6);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("stall_rsp_data", rsp_data, 32'h1E1E_1E1E);
      chk("stall_rsp_rd", {29'b0, rsp_rd}, 32'd2);
      chk("stall_ready_busy", {30'b0, cmd_ready, busy}, 32'b01);
    end
    finish_rsp();
    chk("stall_rsp_cleared", {31'b0, rsp_valid}, 32'd0);

    // Writeback vs host write on the same cycle, same address then a different one.
    for (int k = 0; k < 2; k++) begin
      host_wr(3'd1, 32'h8);
      host_wr(3'd2, 32'h8);
      cmd_valid = 1'b1;
      cmd_op    = 3'b110;
      cmd_rd    = 3'd3;
      cmd_rs1   = 3'd1;
      cmd_rs2   = 3'd2;
      tick();
      cmd_valid = 1'b0;
      tick();
      chk("capture_alu_op", {29'b0, alu_op}, 32'd0);
      wr_en   = 1'b1;
      wr_addr = (k == 0) ? 3'd3 : 3'd4;
      wr_data = 32'hAAAA_0000;
      tick();
      wr_en = 1'b0;
      chk("collide_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("collide_rsp_data", rsp_data, 32'h10);
      finish_rsp();
      read_reg(3'd3, 32'h10, "collide_r3");
      if (k == 1) read_reg(3'd4, 32'hAAAA_0000, "collide_r4");
    end

    // Reset during ISSUE aborts the command.
    host_wr(3'd7, 32'h1234_5678);
    cmd_valid = 1'b1;
    cmd_op    = 3'b110;
    cmd_rd    = 3'd5;
    cmd_rs1   = 3'd7;
    cmd_rs2   = 3'd7;
    tick();
    cmd_valid = 1'b0;
    chk("issue_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("abort_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    for (int r = 0; r < 8; r++) begin
      read_reg(3'(r), 32'h0, $sformatf("abort_r%0d_zero", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
